// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : raster timing source (hsync/vsync, active row/col, strobes)
// Optional: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_en,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           active,
  output logic [$clog2(ACTIVE_ROWS)-1:0] row,
  output logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic                           line_start,
  output logic                           frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]                    frame_cnt
`endif
);

  localparam int c_H_TOTAL = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam int c_RW      = $clog2(ACTIVE_ROWS);
  localparam int c_CW      = $clog2(ACTIVE_COLS);

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(ACTIVE_COLS);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(ACTIVE_COLS + H_FRONT);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(ACTIVE_COLS + H_FRONT + H_SYNC);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(ACTIVE_ROWS);
  localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(ACTIVE_ROWS + V_FRONT);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(ACTIVE_ROWS + V_FRONT + V_SYNC);

  logic [c_HW-1:0] r_h_cnt;
  logic [c_VW-1:0] r_v_cnt;
  logic [c_HW-1:0] w_h_nxt;
  logic [c_VW-1:0] w_v_nxt;
  logic            w_h_wrap;
  logic            w_active_nxt;
  logic            w_hs_nxt;
  logic            w_vs_nxt;
  logic            w_line_nxt;
  logic            w_frame_nxt;

  // Outputs are decoded from the next counter value so they track the counters exactly.
  always_comb begin
    w_h_wrap     = (r_h_cnt == c_H_LAST);
    w_h_nxt      = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    w_v_nxt      = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt    = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end
    w_active_nxt = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
    w_hs_nxt     = (w_h_nxt >= c_HS_BEG) && (w_h_nxt < c_HS_END);
    w_vs_nxt     = (w_v_nxt >= c_VS_BEG) && (w_v_nxt < c_VS_END);
    w_line_nxt   = (w_h_nxt == '0);
    w_frame_nxt  = w_line_nxt && (w_v_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= c_H_LAST;
      r_v_cnt     <= c_V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      row         <= '0;
      col         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      hsync       <= w_hs_nxt ? SYNC_POL : ~SYNC_POL;
      vsync       <= w_vs_nxt ? SYNC_POL : ~SYNC_POL;
      active      <= w_active_nxt;
      row         <= w_active_nxt ? w_v_nxt[c_RW-1:0] : '0;
      col         <= w_active_nxt ? w_h_nxt[c_CW-1:0] : '0;
      line_start  <= w_line_nxt;
      frame_start <= w_frame_nxt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && w_frame_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
